mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates the single shared memory port between instruction fetch (requester A) and data access (requester B).
- Drives the select of the 32-bit 2:1 address mux in front of the memory, plus the memory enable and write-enable.
- Sequences each access over a fixed MEM_LAT-cycle window.
- Fixed priority to B, with an anti-starvation rule that guarantees A forward progress.

Parameters:
- MEM_LAT, 2, memory access latency in cycles; legal range 1..15.
- MAX_WAIT, 2, number of consecutive B grants while A is waiting before A is forced ahead; legal range 1..15.
- CNT_W, 4, width of the latency and wait counters.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst_n  in  1  reset; asynchronous, active-low.
- req_a  in  1  fetch request; held high until ack_a.
- req_b  in  1  data request; held high until ack_b.
- we_b  in  1  data write flag; valid with req_b.
- sel  out  1  address mux select; 0 = A (fetch address), 1 = B (data address).
- mem_en  out  1  memory enable; high for the whole access window.
- mem_we  out  1  memory write enable; equals we_b latched at grant for B, always 0 for A.
- gnt_a  out  1  A owns the port.
- gnt_b  out  1  B owns the port.
- ack_a  out  1  one-cycle completion pulse for A.
- ack_b  out  1  one-cycle completion pulse for B.
- busy  out  1  FSM is in ACCESS.

Behaviour:
- Clock and reset: one clock, Clk. Reset Rst_n is asynchronous, active-low.
- Reset values: state = IDLE, sel = 0, owner = A, lat_cnt = 0, wait_cnt = 0, latched we = 0. All outputs are 0 during reset and in the first cycle after release.
- FSM has two states, IDLE and ACCESS.
- IDLE:
  - Outputs: gnt_*, mem_en, ack_*, busy are 0; sel holds its last value.
  - If neither request is high at the edge, stay in IDLE.
  - Otherwise, at the edge: arbitrate, load owner, sel, latched we and lat_cnt = MEM_LAT-1, then go to ACCESS.
- Arbitration (evaluated in IDLE only):
  - Only req_a: grant A.
  - Only req_b: grant B.
  - Both high: if wait_cnt == MAX_WAIT grant A, else grant B.
- Wait counter update, at each grant:
  - B granted while req_a high: wait_cnt += 1, saturating at MAX_WAIT.
  - A granted, or req_a low: wait_cnt = 0.
- ACCESS:
  - Outputs: busy = 1, mem_en = 1, gnt_<owner> = 1, sel = owner.
  - mem_we = latched we if owner is B, else 0.
  - lat_cnt decrements each cycle. When lat_cnt == 0, ack_<owner> = 1 for that cycle only, and the next state is IDLE.
- Timing: requests sampled at edge k give grant cycles k+1..k+MEM_LAT, ack in cycle k+MEM_LAT, IDLE in cycle k+MEM_LAT+1.
  - With MEM_LAT = 1, grant and ack share one cycle.
  - One mandatory IDLE cycle separates accesses, so each requester sees at most one access per MEM_LAT+1 cycles.
- Requests arriving during ACCESS are not sampled; they wait for the next IDLE.
- A requester may keep its req high across its ack; this is treated as a new request at the next IDLE.
- req or we_b changing mid-access: ignored. The access completes and ack still pulses. we_b is used only as latched at grant.
- sel changes only on the transition IDLE->ACCESS and is stable for the whole window (mux glitch-free per access).
- gnt_a and gnt_b are never high together; ack_a and ack_b are never high together.
- Reset mid-access: immediate return to reset values; no ack is issued for the aborted access; requesters must re-issue after reset.

Test Plan:
- Reset, then req_a = 1 at edge 1 with MEM_LAT = 2 -> gnt_a, sel = 0, mem_en = 1 in cycles 2-3; ack_a = 1 only in cycle 3; idle in cycle 4.
- req_b = 1, we_b = 1, then we_b dropped to 0 in cycle 2 -> sel = 1, mem_we = 1 for both grant cycles; ack_b once.
- req_a and req_b held continuously, MAX_WAIT = 2 -> grant order B, B, A, B, B, A; accesses separated by exactly one idle cycle; wait_cnt returns to 0 after each A grant.
- req_a asserted mid-B-access -> A is not granted until the IDLE cycle after ack_b; sel stays 1 throughout the B window.
- Rst_n pulsed low in cycle 2 of a B access -> all outputs 0 immediately; no ack_b; with req_b still high, a fresh B grant is issued one cycle after reset release.
- MEM_LAT = 1 with req_a held -> gnt_a and ack_a in the same cycle, repeating every 2 cycles; gnt_a and gnt_b never overlap (checked by assertion).

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter: fetch (A) vs data (B), fixed priority to B with
// a wait counter that forces A ahead after MAX_WAIT consecutive B grants.
//
// state  | meaning
// IDLE   | port free; arbitrate and load owner/sel/we/latency on any request
// ACCESS | access window of MEM_LAT cycles; ack to owner when lat_cnt hits 0
module mem_port_arbiter #(
  parameter int MEM_LAT  = 2,
  parameter int MAX_WAIT = 2,
  parameter int CNT_W    = 4
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic we_b,
  output logic sel,
  output logic mem_en,
  output logic mem_we,
  output logic gnt_a,
  output logic gnt_b,
  output logic ack_a,
  output logic ack_b,
  output logic busy
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             sel_q, sel_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             grant_b;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      lat_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      lat_q   <= lat_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    sel_d   = sel_q;
    we_d    = we_q;
    lat_d   = lat_q;
    wait_d  = wait_q;
    grant_b = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          // B wins unless A has already waited out MAX_WAIT B grants
          grant_b = req_b && !(req_a && (wait_q == WAIT_MAX));
          owner_d = grant_b;
          sel_d   = grant_b;
          we_d    = grant_b && we_b;
          lat_d   = LAT_LOAD;
          state_d = ACCESS;
          if (grant_b && req_a)
            wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
          else
            wait_d = '0;
        end
      end
      ACCESS: begin
        if (lat_q == '0) state_d = IDLE;
        else             lat_d   = lat_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // sel is a register so the address mux only moves on IDLE->ACCESS
  assign busy   = (state_q == ACCESS);
  assign sel    = sel_q;
  assign mem_en = busy;
  assign mem_we = busy && owner_q && we_q;
  assign gnt_a  = busy && !owner_q;
  assign gnt_b  = busy && owner_q;
  assign ack_a  = gnt_a && (lat_q == '0);
  assign ack_b  = gnt_b && (lat_q == '0);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 instance for the main
// sequences and a MEM_LAT=1 instance for the single-cycle window.
module tb_mem_port_arbiter;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  logic req_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic sel, mem_en, mem_we, gnt_a, gnt_b, ack_a, ack_b, busy;
  logic req_a1 = 1'b0, req_b1 = 1'b0, we_b1 = 1'b0;
  logic sel1, mem_en1, mem_we1, gnt_a1, gnt_b1, ack_a1, ack_b1, busy1;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  mem_port_arbiter #(.MEM_LAT(2), .MAX_WAIT(2), .CNT_W(4)) u_dut (
    .Clk(Clk), .Rst_n(Rst_n), .req_a(req_a), .req_b(req_b), .we_b(we_b),
    .sel(sel), .mem_en(mem_en), .mem_we(mem_we), .gnt_a(gnt_a), .gnt_b(gnt_b),
    .ack_a(ack_a), .ack_b(ack_b), .busy(busy)
  );

  mem_port_arbiter #(.MEM_LAT(1), .MAX_WAIT(2), .CNT_W(4)) u_dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .req_a(req_a1), .req_b(req_b1), .we_b(we_b1),
    .sel(sel1), .mem_en(mem_en1), .mem_we(mem_we1), .gnt_a(gnt_a1), .gnt_b(gnt_b1),
    .ack_a(ack_a1), .ack_b(ack_b1), .busy(busy1)
  );

  // output vector: {sel, mem_en, mem_we, gnt_a, gnt_b, ack_a, ack_b, busy}
  localparam logic [7:0] O_IDLE_A = 8'h00;
  localparam logic [7:0] O_IDLE_B = 8'h80;
  localparam logic [7:0] O_A_GNT  = 8'h51;
  localparam logic [7:0] O_A_ACK  = 8'h55;
  localparam logic [7:0] O_BW_GNT = 8'hE9;
  localparam logic [7:0] O_BW_ACK = 8'hEB;
  localparam logic [7:0] O_BR_GNT = 8'hC9;
  localparam logic [7:0] O_BR_ACK = 8'hCB;

  function automatic logic [7:0] outs0();
    return {sel, mem_en, mem_we, gnt_a, gnt_b, ack_a, ack_b, busy};
  endfunction

  function automatic logic [7:0] outs1();
    return {sel1, mem_en1, mem_we1, gnt_a1, gnt_b1, ack_a1, ack_b1, busy1};
  endfunction

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=%02h expected=%02h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  always @(negedge Clk) begin
    if (Rst_n) begin
      assert (!(gnt_a && gnt_b) && !(ack_a && ack_b) && !(gnt_a1 && gnt_b1))
      else begin
        failures++;
        $display("FAIL overlap: gnt/ack of both requesters high at %0t", $time);
      end
    end
  end

  logic [7:0] seq_exp [0:17];

  initial begin
    // reset held
    step();
    check_val("reset_outs", outs0(), 8'h00);
    check_val("reset_outs1", outs1(), 8'h00);
    step();

    // single A access
    Rst_n = 1'b1;
    req_a = 1'b1;
    check_val("first_cycle_after_reset", outs0(), 8'h00);
    step(); check_val("a_gnt", outs0(), O_A_GNT);
    step(); check_val("a_ack", outs0(), O_A_ACK);
    req_a = 1'b0;
    step(); check_val("a_idle", outs0(), O_IDLE_A);

    // B write, we_b dropped mid-access
    req_b = 1'b1; we_b = 1'b1;
    step(); check_val("bw_gnt", outs0(), O_BW_GNT);
    we_b = 1'b0;
    step(); check_val("bw_ack_we_latched", outs0(), O_BW_ACK);
    req_b = 1'b0;
    step(); check_val("bw_idle_sel_hold", outs0(), O_IDLE_B);

    // both held: B, B, A, B, B, A
    seq_exp = '{O_BR_GNT, O_BR_ACK, O_IDLE_B, O_BR_GNT, O_BR_ACK, O_IDLE_B,
                O_A_GNT,  O_A_ACK,  O_IDLE_A, O_BR_GNT, O_BR_ACK, O_IDLE_B,
                O_BR_GNT, O_BR_ACK, O_IDLE_B, O_A_GNT,  O_A_ACK,  O_IDLE_A};
    req_a = 1'b1; req_b = 1'b1;
    for (int i = 0; i < 18; i++) begin
      step();
      check_val($sformatf("starve_seq_%0d", i), outs0(), seq_exp[i]);
      if (i == 16) begin
        req_a = 1'b0; req_b = 1'b0;
      end
    end

    // req_a arriving mid-B access waits for the next IDLE
    req_b = 1'b1;
    step(); check_val("midb_gnt", outs0(), O_BR_GNT);
    req_a = 1'b1;
    step(); check_val("midb_ack", outs0(), O_BR_ACK);
    req_b = 1'b0;
    step(); check_val("midb_idle", outs0(), O_IDLE_B);
    step(); check_val("midb_a_gnt", outs0(), O_A_GNT);
    step(); check_val("midb_a_ack", outs0(), O_A_ACK);
    req_a = 1'b0;
    step(); check_val("midb_a_idle", outs0(), O_IDLE_A);

    // reset in the second cycle of a B access
    req_b = 1'b1; we_b = 1'b1;
    step(); check_val("rst_b_gnt", outs0(), O_BW_GNT);
    step();
    Rst_n = 1'b0;
    #1;
    check_val("rst_abort_no_ack", outs0(), 8'h00);
    step(); check_val("rst_held", outs0(), 8'h00);
    Rst_n = 1'b1;
    check_val("rst_release_cycle", outs0(), 8'h00);
    step(); check_val("rst_fresh_gnt", outs0(), O_BW_GNT);
    step(); check_val("rst_fresh_ack", outs0(), O_BW_ACK);
    req_b = 1'b0; we_b = 1'b0;
    step(); check_val("rst_fresh_idle", outs0(), O_IDLE_B);

    // MEM_LAT = 1: grant and ack share a cycle, repeat every 2 cycles
    req_a1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check_val($sformatf("lat1_gnt_ack_%0d", i), outs1(), O_A_ACK);
      if (i == 2) req_a1 = 1'b0;
      step(); check_val($sformatf("lat1_idle_%0d", i), outs1(), O_IDLE_A);
    end
    step(); check_val("lat1_stays_idle", outs1(), O_IDLE_A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
